// File: rtl/legv8_multicycle_control_if.sv
// Memory handshake bundle between the LEGv8 multicycle sequencer (master)
// and the instruction/data memories (slave).
interface legv8_multicycle_control_if;
   logic InstReq;
   logic InstAck;
   logic DataReq;
   logic DataAck;
   logic DataWrite;

   modport master (output InstReq, output DataReq, output DataWrite,
                   input  InstAck, input  DataAck);
   modport slave  (input  InstReq, input  DataReq, input  DataWrite,
                   output InstAck, output DataAck);
endinterface

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// ack timeout into a sticky HALT, and a retired-instruction counter.
module legv8_multicycle_control #(
   parameter int ACK_TIMEOUT = 255,
   parameter int RET_W       = 32
) (
   input  logic                        CLK,
   input  logic                        Reset,
   legv8_multicycle_control_if.master  mem,
   input  logic [10:0]                 Opcode,
   input  logic                        Zero,
   output logic                        IRWrite,
   output logic                        PCWrite,
   output logic                        PCSrc,
   output logic                        Reg2Loc,
   output logic                        ALUSrc,
   output logic                        MemtoReg,
   output logic                        RegWrite,
   output logic [1:0]                  ALUOp,
   output logic                        Halted,
   output logic [RET_W-1:0]            Retired,
   output logic [2:0]                  State
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [2:0] C_R   = 3'd0;
   localparam logic [2:0] C_LD  = 3'd1;
   localparam logic [2:0] C_ST  = 3'd2;
   localparam logic [2:0] C_CB  = 3'd3;
   localparam logic [2:0] C_UB  = 3'd4;
   localparam logic [2:0] C_ILL = 3'd5;

   localparam int              WAIT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   logic [2:0]        state_q, state_d;
   logic [2:0]        cls_q, cls_d;
   logic [2:0]        dec_cls;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [RET_W-1:0]  ret_q, ret_d;
   logic              inst_req, data_req, data_write;

   always_comb begin
      dec_cls = C_ILL;
      casez (Opcode)
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: dec_cls = C_R;
         11'b11111000010: dec_cls = C_LD;
         11'b11111000000: dec_cls = C_ST;
         11'b10110100???: dec_cls = C_CB;
         11'b000101?????: dec_cls = C_UB;
         default:         dec_cls = C_ILL;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      wait_d     = wait_q;
      ret_d      = ret_q;
      inst_req   = 1'b0;
      data_req   = 1'b0;
      data_write = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      Reg2Loc    = 1'b0;
      ALUSrc     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUOp      = 2'b00;
      Halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            inst_req = 1'b1;
            // An ack on the last permitted wait cycle still wins over the timeout.
            if (mem.InstAck) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            cls_d   = dec_cls;
            state_d = (dec_cls == C_ILL) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            case (cls_q)
               C_R: begin
                  ALUOp   = 2'b10;
                  state_d = S_WB;
               end
               C_LD: begin
                  ALUSrc  = 1'b1;
                  state_d = S_MEM;
               end
               C_ST: begin
                  ALUSrc  = 1'b1;
                  Reg2Loc = 1'b1;
                  state_d = S_MEM;
               end
               C_CB: begin
                  Reg2Loc = 1'b1;
                  ALUOp   = 2'b01;
                  PCWrite = Zero;
                  PCSrc   = Zero;
                  state_d = S_FETCH;
               end
               C_UB: begin
                  PCWrite = 1'b1;
                  PCSrc   = 1'b1;
                  state_d = S_FETCH;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            // Reg2Loc stays up for stores so the store data read port is stable.
            data_req   = 1'b1;
            ALUSrc     = 1'b1;
            data_write = (cls_q == C_ST);
            Reg2Loc    = (cls_q == C_ST);
            if (mem.DataAck) begin
               state_d = (cls_q == C_ST) ? S_FETCH : S_WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (cls_q == C_LD);
            state_d  = S_FETCH;
         end
         S_HALT: Halted = 1'b1;
         default: state_d = S_HALT;
      endcase
      if (state_d != state_q) begin
         wait_d = '0;
      end
      if ((state_d == S_FETCH) &&
          ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))) begin
         ret_d = ret_q + RET_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_FETCH;
         cls_q   <= C_R;
         wait_q  <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         ret_q   <= ret_d;
      end
   end

   assign mem.InstReq   = inst_req;
   assign mem.DataReq   = data_req;
   assign mem.DataWrite = data_write;
   assign Retired       = ret_q;
   assign State         = state_q;
endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for the LEGv8 multicycle sequencer with a scoreboard queue of
// expected control vectors and retired counts.
module tb_legv8_multicycle_control;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_B    = 11'b00010110011;
   localparam logic [10:0] OP_ILL  = 11'h7FF;

   localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;

   // Enable order: InstReq DataReq DataWrite IRWrite PCWrite PCSrc Reg2Loc ALUSrc MemtoReg RegWrite
   localparam logic [9:0] E_NONE  = 10'b0000000000;
   localparam logic [9:0] E_FREQ  = 10'b1000000000;
   localparam logic [9:0] E_FACK  = 10'b1001100000;
   localparam logic [9:0] E_EXLD  = 10'b0000000100;
   localparam logic [9:0] E_EXST  = 10'b0000001100;
   localparam logic [9:0] E_MEMLD = 10'b0100000100;
   localparam logic [9:0] E_MEMST = 10'b0110001100;
   localparam logic [9:0] E_WBLD  = 10'b0000000011;
   localparam logic [9:0] E_WBR   = 10'b0000000001;
   localparam logic [9:0] E_CBT   = 10'b0000111000;
   localparam logic [9:0] E_CBN   = 10'b0000001000;
   localparam logic [9:0] E_UB    = 10'b0000110000;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [10:0] Opcode;
   logic        Zero;
   logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite, Halted;
   logic [1:0]  ALUOp;
   logic [31:0] Retired;
   logic [2:0]  State;

   legv8_multicycle_control_if bus ();

   legv8_multicycle_control #(.ACK_TIMEOUT(4), .RET_W(32)) dut (
      .CLK(CLK), .Reset(Reset), .mem(bus), .Opcode(Opcode), .Zero(Zero),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
      .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUOp(ALUOp),
      .Halted(Halted), .Retired(Retired), .State(State)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      bit          is_ret;
      logic [31:0] exp;
   } sb_t;

   sb_t sbq[$];
   int  checks = 0;
   int  errors = 0;

   function automatic logic [31:0] vec(input logic [2:0] st, input logic [9:0] en,
                                       input logic [1:0] aop);
      return {16'd0, st, en, aop, (st == H)};
   endfunction

   task automatic push(input string tag, input bit is_ret, input logic [31:0] exp);
      sb_t e;
      e.tag = tag; e.is_ret = is_ret; e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic check_all();
      sb_t e;
      logic [31:0] obs;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.is_ret) obs = Retired;
         else obs = {16'd0, State, bus.InstReq, bus.DataReq, bus.DataWrite, IRWrite,
                     PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite, ALUOp, Halted};
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   // Called just after a rising edge; drives one cycle and checks it on the falling edge.
   task automatic cyc(input string tag, input logic [10:0] op, input logic z,
                      input logic ia, input logic da, input logic [2:0] st,
                      input logic [9:0] en, input logic [1:0] aop, input int ret = -1);
      Opcode = op; Zero = z; bus.InstAck = ia; bus.DataAck = da;
      push(tag, 1'b0, vec(st, en, aop));
      if (ret >= 0) push({tag, "_ret"}, 1'b1, ret);
      @(negedge CLK);
      check_all();
      @(posedge CLK);
      #1;
   endtask

   // Asynchronous pulse entirely between edges; leaves the bench inside a FETCH cycle.
   task automatic do_reset(input string tag);
      bus.InstAck = 1'b0; bus.DataAck = 1'b0;
      Reset = 1'b1;
      #2;
      push(tag, 1'b0, vec(F, E_FREQ, 2'b00));
      push({tag, "_ret"}, 1'b1, 32'd0);
      check_all();
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0; Opcode = OP_ADD; Zero = 1'b0; bus.InstAck = 1'b0; bus.DataAck = 1'b0;
      @(posedge CLK);
      #1;
      do_reset("rst0");

      // ADD, instant acks
      cyc("add_f", OP_ADD, 0, 1, 0, F, E_FACK, 2'b00);
      cyc("add_d", OP_ADD, 0, 1, 0, D, E_NONE, 2'b00);
      cyc("add_e", OP_ADD, 0, 1, 0, E, E_NONE, 2'b10);
      cyc("add_w", OP_ADD, 0, 1, 0, W, E_WBR,  2'b00);
      cyc("add_n", OP_ADD, 0, 0, 0, F, E_FREQ, 2'b00, 1);

      // LDUR, data ack delayed two cycles
      do_reset("rst_ld");
      cyc("ld_f",  OP_LDUR, 0, 1, 0, F, E_FACK,  2'b00);
      cyc("ld_d",  OP_LDUR, 0, 0, 0, D, E_NONE,  2'b00);
      cyc("ld_e",  OP_LDUR, 0, 0, 0, E, E_EXLD,  2'b00);
      cyc("ld_m0", OP_LDUR, 0, 0, 0, M, E_MEMLD, 2'b00);
      cyc("ld_m1", OP_LDUR, 0, 1, 0, M, E_MEMLD, 2'b00);
      cyc("ld_m2", OP_LDUR, 0, 0, 1, M, E_MEMLD, 2'b00);
      cyc("ld_w",  OP_LDUR, 0, 0, 1, W, E_WBLD,  2'b00);
      cyc("ld_n",  OP_LDUR, 0, 0, 0, F, E_FREQ,  2'b00, 1);

      // CBZ taken, CBZ not taken, then B
      do_reset("rst_cb");
      cyc("cb1_f", OP_CBZ, 0, 1, 0, F, E_FACK, 2'b00);
      cyc("cb1_d", OP_CBZ, 0, 0, 0, D, E_NONE, 2'b00);
      cyc("cb1_e", OP_CBZ, 1, 0, 0, E, E_CBT,  2'b01);
      cyc("cb2_f", OP_CBZ, 1, 1, 0, F, E_FACK, 2'b00, 1);
      cyc("cb2_d", OP_CBZ, 1, 0, 0, D, E_NONE, 2'b00);
      cyc("cb2_e", OP_CBZ, 0, 0, 0, E, E_CBN,  2'b01);
      cyc("b_f",   OP_B,   0, 1, 0, F, E_FACK, 2'b00, 2);
      cyc("b_d",   OP_B,   0, 0, 0, D, E_NONE, 2'b00);
      cyc("b_e",   OP_B,   0, 0, 0, E, E_UB,   2'b00);
      cyc("b_n",   OP_B,   0, 0, 0, F, E_FREQ, 2'b00, 3);

      // Illegal opcode halts and ignores acks
      do_reset("rst_ill");
      cyc("ill_f", OP_ILL, 0, 1, 0, F, E_FACK, 2'b00);
      cyc("ill_d", OP_ILL, 0, 0, 0, D, E_NONE, 2'b00);
      for (int i = 0; i < 20; i++) begin
         cyc("ill_h", OP_ADD, i[2], i[0], i[1], H, E_NONE, 2'b00);
      end
      do_reset("rst_clr");

      // Fetch timeout with ACK_TIMEOUT=4
      for (int i = 0; i < 4; i++) cyc("to_wait", OP_ADD, 0, 0, 0, F, E_FREQ, 2'b00);
      cyc("to_halt", OP_ADD, 0, 1, 1, H, E_NONE, 2'b00);

      // Ack on the last wait cycle wins; then STUR completes
      do_reset("rst_to2");
      for (int i = 0; i < 3; i++) cyc("late_wait", OP_STUR, 0, 0, 0, F, E_FREQ, 2'b00);
      cyc("late_ack", OP_STUR, 0, 1, 0, F, E_FACK,  2'b00);
      cyc("st1_d",    OP_STUR, 0, 0, 0, D, E_NONE,  2'b00);
      cyc("st1_e",    OP_STUR, 0, 0, 0, E, E_EXST,  2'b00);
      cyc("st1_m",    OP_STUR, 0, 1, 1, M, E_MEMST, 2'b00);
      cyc("st2_f",    OP_STUR, 0, 1, 0, F, E_FACK,  2'b00, 1);
      cyc("st2_d",    OP_STUR, 0, 0, 0, D, E_NONE,  2'b00);
      cyc("st2_e",    OP_STUR, 0, 0, 0, E, E_EXST,  2'b00);
      cyc("st2_m",    OP_STUR, 0, 0, 0, M, E_MEMST, 2'b00);

      // Reset while the store request is outstanding
      do_reset("rst_mid");
      cyc("post_rst", OP_ADD, 0, 0, 0, F, E_FREQ, 2'b00, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
